// File: rtl/coin_acceptor_pkg.sv
// Shared types for the coin acceptor: FSM state encoding, the 4-bit credit
// type and the credit ceiling.
package coin_acceptor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_START   = 3'd2,
    ST_WASHING = 3'd3,
    ST_REFUND  = 3'd4
  } state_t;

  typedef logic [3:0] credit_t;

  localparam credit_t MAX_CREDIT = 4'd15;

endpackage

// File: rtl/coin_acceptor_debounce.sv
// coin_debounce: two-flop synchronizer plus debouncer for the raw coin sensor.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_coin_sensor     raw asynchronous, bouncy sensor (high while a coin passes)
//   o_coin_pulse      one-cycle pulse when a coin edge is accepted
// The debounced level only flips after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; a pulse is emitted on the
// cycle a rising flip is decided, so a coin is accepted once and cannot be
// accepted again until the sensor has been stably low.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_coin_sensor,
  output logic o_coin_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_differs;

  assign w_differs    = (r_sync2 != r_level);
  assign o_coin_pulse = w_differs && (r_cnt == '0) && r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= RELOAD;
    end else begin
      r_sync1 <= i_coin_sensor;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= RELOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= RELOAD;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: credit collection, wash start and refund sequencing for a
// coin-operated washer.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_coin_sensor      raw coin-slot sensor
//   i_sel_double       user selection of a double wash (level)
//   i_start_btn        start request (one-cycle pulse)
//   i_cancel_btn       refund request (one-cycle pulse)
//   i_wash_done        washer controller: cycle complete (level)
//   i_refund_ack       hopper: refund paid (level)
//   o_coin_in          paid-start pulse to the washer controller
//   o_double_wash      double wash selected for the running cycle
//   o_credit           coins currently held
//   o_refund_req       refund requested
//   o_refund_count     coins to refund, valid with o_refund_req
//   o_coin_reject      accepted coin edge that was not credited
//   o_busy             high in START and WASHING
//
// state   | meaning
// IDLE    | no credit held, waiting for the first coin
// COLLECT | holding credit, waiting for start or cancel
// START   | one-cycle paid start, o_coin_in high
// WASHING | washer running, coins still credited
// REFUND  | refund requested, waiting for hopper ack
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SINGLE_PRICE    = 2,
  parameter int unsigned DOUBLE_PRICE    = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_coin_sensor,
  input  logic       i_sel_double,
  input  logic       i_start_btn,
  input  logic       i_cancel_btn,
  input  logic       i_wash_done,
  input  logic       i_refund_ack,
  output logic       o_coin_in,
  output logic       o_double_wash,
  output logic [3:0] o_credit,
  output logic       o_refund_req,
  output logic [3:0] o_refund_count,
  output logic       o_coin_reject,
  output logic       o_busy
);

  localparam credit_t SGL_PRICE = credit_t'(SINGLE_PRICE);
  localparam credit_t DBL_PRICE = credit_t'(DOUBLE_PRICE);

  state_t  r_state, w_state_nxt;
  credit_t r_credit, w_credit_nxt;
  credit_t r_refund_count, w_refund_count_nxt;
  logic    r_double, w_double_nxt;
  logic    r_refund_req, w_refund_req_nxt;
  logic    r_coin_reject, w_coin_reject_nxt;
  logic    r_wash_done_q;

  logic    w_coin_pulse;
  credit_t w_price;
  credit_t w_credit_plus;
  logic    w_overflow;
  logic    w_wash_rise;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_coin_sensor (i_coin_sensor),
    .o_coin_pulse  (w_coin_pulse)
  );

  assign w_price       = i_sel_double ? DBL_PRICE : SGL_PRICE;
  assign w_overflow    = w_coin_pulse && (r_credit == MAX_CREDIT);
  // Credit after this cycle's coin, saturating at MAX_CREDIT.
  assign w_credit_plus = (w_coin_pulse && !w_overflow) ? r_credit + 4'd1 : r_credit;
  // Registered previous level, so a level already high on WASHING entry is not a rise.
  assign w_wash_rise   = i_wash_done && !r_wash_done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_refund_count <= '0;
      r_double       <= 1'b0;
      r_refund_req   <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_wash_done_q  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_refund_count <= w_refund_count_nxt;
      r_double       <= w_double_nxt;
      r_refund_req   <= w_refund_req_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_wash_done_q  <= i_wash_done;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_refund_count_nxt = r_refund_count;
    w_double_nxt       = r_double;
    w_refund_req_nxt   = r_refund_req;
    w_coin_reject_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_coin_reject_nxt = w_overflow;
        if (w_coin_pulse) begin
          w_credit_nxt = w_credit_plus;
          w_state_nxt  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        w_coin_reject_nxt = w_overflow;
        if (i_cancel_btn && (r_credit != '0)) begin
          w_credit_nxt       = w_credit_plus;
          w_refund_count_nxt = w_credit_plus;
          w_refund_req_nxt   = 1'b1;
          w_state_nxt        = ST_REFUND;
        end else if (i_start_btn && (r_credit >= w_price)) begin
          // Sufficiency is judged on pre-coin credit, so this cannot underflow.
          w_credit_nxt = w_credit_plus - w_price;
          w_double_nxt = i_sel_double;
          w_state_nxt  = ST_START;
        end else begin
          w_credit_nxt = w_credit_plus;
        end
      end
      ST_START: begin
        w_coin_reject_nxt = w_overflow;
        w_credit_nxt      = w_credit_plus;
        w_state_nxt       = ST_WASHING;
      end
      ST_WASHING: begin
        w_coin_reject_nxt = w_overflow;
        w_credit_nxt      = w_credit_plus;
        if (w_wash_rise) begin
          w_double_nxt = 1'b0;
          w_state_nxt  = (w_credit_plus != '0) ? ST_COLLECT : ST_IDLE;
        end
      end
      ST_REFUND: begin
        w_coin_reject_nxt = w_coin_pulse;
        if (i_refund_ack) begin
          w_credit_nxt       = '0;
          w_refund_count_nxt = '0;
          w_refund_req_nxt   = 1'b0;
          w_state_nxt        = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_coin_in      = (r_state == ST_START);
  assign o_busy         = (r_state == ST_START) || (r_state == ST_WASHING);
  assign o_double_wash  = r_double;
  assign o_credit       = r_credit;
  assign o_refund_req   = r_refund_req;
  assign o_refund_count = r_refund_count;
  assign o_coin_reject  = r_coin_reject;

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: table of operations with expected output
// snapshots, plus hand-written sequences for debounce latency, wash_done
// level on entry and coin-with-start in the same cycle. Expected snapshots
// are queued when stimulus completes and compared at the next falling edge.
module tb_coin_acceptor;

  logic       clk;
  logic       i_reset;
  logic       i_coin_sensor;
  logic       i_sel_double;
  logic       i_start_btn;
  logic       i_cancel_btn;
  logic       i_wash_done;
  logic       i_refund_ack;
  logic       o_coin_in;
  logic       o_double_wash;
  logic [3:0] o_credit;
  logic       o_refund_req;
  logic [3:0] o_refund_count;
  logic       o_coin_reject;
  logic       o_busy;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .SINGLE_PRICE    (2),
    .DOUBLE_PRICE    (3)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_coin_sensor  (i_coin_sensor),
    .i_sel_double   (i_sel_double),
    .i_start_btn    (i_start_btn),
    .i_cancel_btn   (i_cancel_btn),
    .i_wash_done    (i_wash_done),
    .i_refund_ack   (i_refund_ack),
    .o_coin_in      (o_coin_in),
    .o_double_wash  (o_double_wash),
    .o_credit       (o_credit),
    .o_refund_req   (o_refund_req),
    .o_refund_count (o_refund_count),
    .o_coin_reject  (o_coin_reject),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {OP_RESET, OP_COIN, OP_START, OP_START_CANCEL, OP_WASH_DONE, OP_ACK} op_t;

  typedef struct {
    string      name;
    op_t        op;
    int         n;
    logic       sel;
    logic [3:0] credit;
    logic       busy;
    logic       dbl;
    logic       rreq;
    logic [3:0] rcnt;
    int         d_coin_in;
    int         d_reject;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] credit;
    logic       busy;
    logic       dbl;
    logic       rreq;
    logic [3:0] rcnt;
    int         coin_in_total;
    int         reject_total;
  } snap_t;

  localparam int NV = 18;
  vec_t  vecs[NV];
  snap_t exp_q[$];
  snap_t mon_s;

  int n_checks = 0;
  int n_fail   = 0;
  int n_coin_in = 0;
  int n_reject  = 0;
  int exp_coin_in_total = 0;
  int exp_reject_total  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (o_coin_in === 1'b1) n_coin_in++;
    if (o_coin_reject === 1'b1) n_reject++;
    if (exp_q.size() > 0) begin
      mon_s = exp_q.pop_front();
      chk({mon_s.name, ".credit"},       32'(o_credit),       32'(mon_s.credit));
      chk({mon_s.name, ".busy"},         32'(o_busy),         32'(mon_s.busy));
      chk({mon_s.name, ".double_wash"},  32'(o_double_wash),  32'(mon_s.dbl));
      chk({mon_s.name, ".refund_req"},   32'(o_refund_req),   32'(mon_s.rreq));
      chk({mon_s.name, ".refund_count"}, 32'(o_refund_count), 32'(mon_s.rcnt));
      chk({mon_s.name, ".coin_in_pulses"}, 32'(n_coin_in),    32'(mon_s.coin_in_total));
      chk({mon_s.name, ".reject_pulses"},  32'(n_reject),     32'(mon_s.reject_total));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin();
    i_coin_sensor = 1'b1;
    tick(6);
    i_coin_sensor = 1'b0;
    tick(6);
  endtask

  task automatic expect_snap(input string nm, input logic [3:0] cr, input logic b,
                             input logic d, input logic rq, input logic [3:0] rc);
    snap_t s;
    s.name = nm; s.credit = cr; s.busy = b; s.dbl = d; s.rreq = rq; s.rcnt = rc;
    s.coin_in_total = exp_coin_in_total;
    s.reject_total  = exp_reject_total;
    exp_q.push_back(s);
  endtask

  task automatic apply(input vec_t v);
    i_sel_double = v.sel;
    case (v.op)
      OP_RESET:        begin i_reset = 1'b1; tick(2); i_reset = 1'b0; end
      OP_COIN:         repeat (v.n) coin();
      OP_START:        begin i_start_btn = 1'b1; tick(1); i_start_btn = 1'b0; end
      OP_START_CANCEL: begin i_start_btn = 1'b1; i_cancel_btn = 1'b1; tick(1);
                             i_start_btn = 1'b0; i_cancel_btn = 1'b0; end
      OP_WASH_DONE:    begin i_wash_done = 1'b1; tick(3); i_wash_done = 1'b0; end
      OP_ACK:          begin i_refund_ack = 1'b1; tick(1); i_refund_ack = 1'b0; end
      default:         tick(1);
    endcase
    tick(3);
    exp_coin_in_total += v.d_coin_in;
    exp_reject_total  += v.d_reject;
    expect_snap(v.name, v.credit, v.busy, v.dbl, v.rreq, v.rcnt);
  endtask

  initial begin
    i_reset = 1'b1; i_coin_sensor = 1'b0; i_sel_double = 1'b0; i_start_btn = 1'b0;
    i_cancel_btn = 1'b0; i_wash_done = 1'b0; i_refund_ack = 1'b0;

    //           name              op               n   sel   cr     busy  dbl   rreq  rcnt  dci dr
    vecs[0]  = '{"reset",          OP_RESET,        0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[1]  = '{"two_coins",      OP_COIN,         2,  1'b0, 4'd2,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[2]  = '{"single_start",   OP_START,        0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1, 0};
    vecs[3]  = '{"done_to_idle",   OP_WASH_DONE,    0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[4]  = '{"two_coins_dbl",  OP_COIN,         2,  1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[5]  = '{"dbl_short",      OP_START,        0,  1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[6]  = '{"third_coin",     OP_COIN,         1,  1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[7]  = '{"dbl_start",      OP_START,        0,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1, 0};
    vecs[8]  = '{"coin_washing",   OP_COIN,         1,  1'b1, 4'd1,  1'b1, 1'b1, 1'b0, 4'd0, 0, 0};
    vecs[9]  = '{"done_collect",   OP_WASH_DONE,    0,  1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[10] = '{"to_three",       OP_COIN,         2,  1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[11] = '{"cancel_wins",    OP_START_CANCEL, 0,  1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 4'd3, 0, 0};
    vecs[12] = '{"coin_refund",    OP_COIN,         1,  1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 4'd3, 0, 1};
    vecs[13] = '{"refund_ack",     OP_ACK,          0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[14] = '{"fifteen",        OP_COIN,         15, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 0, 0};
    vecs[15] = '{"sixteenth",      OP_COIN,         1,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 0, 1};
    vecs[16] = '{"start_from_15",  OP_START,        0,  1'b0, 4'd13, 1'b1, 1'b0, 1'b0, 4'd0, 1, 0};
    vecs[17] = '{"reset_mid_wash", OP_RESET,        0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 0, 0};

    tick(1);
    for (int i = 0; i < NV; i++) apply(vecs[i]);

    // Bounce (two highs, one low) then a clean 6-cycle hold: credit must
    // appear exactly 2+4 edges after the hold begins, and only once.
    i_sel_double = 1'b0;
    i_coin_sensor = 1'b1; tick(2);
    i_coin_sensor = 1'b0; tick(1);
    i_coin_sensor = 1'b1;
    tick(5);
    expect_snap("bounce_edge5", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    expect_snap("bounce_edge6", 4'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    i_coin_sensor = 1'b0;
    tick(10);
    expect_snap("bounce_once", 4'd1, 1'b0, 1'b0, 1'b0, 4'd0);

    // wash_done already high when WASHING is entered must not end the wash.
    coin();
    i_wash_done = 1'b1;
    i_start_btn = 1'b1; tick(1); i_start_btn = 1'b0;
    tick(5);
    exp_coin_in_total += 1;
    expect_snap("done_level_held", 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    i_wash_done = 1'b0; tick(2);
    i_wash_done = 1'b1; tick(3);
    expect_snap("done_after_rise", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    i_wash_done = 1'b0; tick(1);

    // Coin accepted on the same edge as a valid start: 3 + 1 - 2 = 2.
    repeat (3) coin();
    expect_snap("pre_coin_start", 4'd3, 1'b0, 1'b0, 1'b0, 4'd0);
    i_coin_sensor = 1'b1;
    tick(5);
    i_start_btn = 1'b1; tick(1); i_start_btn = 1'b0;
    tick(2);
    i_coin_sensor = 1'b0;
    tick(6);
    exp_coin_in_total += 1;
    expect_snap("coin_with_start", 4'd2, 1'b1, 1'b0, 1'b0, 4'd0);
    i_wash_done = 1'b1; tick(3); i_wash_done = 1'b0;
    tick(2);
    expect_snap("collect_after", 4'd2, 1'b0, 1'b0, 1'b0, 4'd0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
